matrix_ram_master: RTL

MATRIX_RAM_MASTER -- requirements
Module: matrix_ram_master

---
 rtl/matrix_ram_pkg.sv | 18 +
 rtl/ram_rd_latency_pipe.sv | 34 +++
 rtl/matrix_ram_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/matrix_ram_pkg.sv
// Shared definitions for the matrix RAM master.
// Contents: default parameter widths and the transfer FSM state type.
package matrix_ram_pkg;

  localparam int unsigned DefAddrW       = 16;
  localparam int unsigned DefDataW       = 32;
  localparam int unsigned DefLenW        = 16;
  localparam int unsigned DefReadLatency = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDrain,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/ram_rd_latency_pipe.sv
// Read-latency tracker: delays an "address issued" flag by LATENCY cycles so the
// sink sees a valid strobe aligned with RAM read data.
// Ports:
//   clk, reset : clock and synchronous active-high reset (clears all in-flight flags)
//   i_issue    : a read address is presented to the RAM this cycle
//   o_valid    : read data for an address issued LATENCY cycles ago is on the bus
//   o_last     : o_valid is high and no other read is still in flight
module ram_rd_latency_pipe #(
  parameter int unsigned LATENCY = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_issue,
  output logic o_valid,
  output logic o_last
);

  localparam logic [LATENCY-1:0] TailOnly = LATENCY'(1) << (LATENCY - 1);

  logic [LATENCY-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      // Shift towards the MSB; the bit falling off the top has already been emitted.
      r_pipe <= LATENCY'({r_pipe, i_issue});
    end
  end

  assign o_valid = r_pipe[LATENCY-1];
  assign o_last  = (r_pipe == TailOnly);

endmodule

// File: rtl/matrix_ram_master.sv
// Streaming RAM master: moves cmd_len words between a word-addressed RAM and a
// read sink / write source, starting at cmd_addr.
// Optional feature: define RAM_MASTER_STRIDE_EN to add cmd_stride and advance the
// address by the latched stride instead of 1.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   cmd_valid/cmd_ready             : command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len    : direction, start address, word count
//   cmd_stride                      : address increment (RAM_MASTER_STRIDE_EN only)
//   busy, done                      : transfer in progress, one-cycle completion pulse
//   avm_*                           : RAM port (address, chipselect, write, data, byteenable)
//   rd_data/rd_valid                : read words to sink, no backpressure
//   wr_data/wr_valid/wr_ready       : write-word source handshake
module matrix_ram_master
  import matrix_ram_pkg::*;
#(
  parameter int unsigned ADDR_W       = DefAddrW,
  parameter int unsigned DATA_W       = DefDataW,
  parameter int unsigned LEN_W        = DefLenW,
  parameter int unsigned READ_LATENCY = DefReadLatency
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
`ifdef RAM_MASTER_STRIDE_EN
  input  logic [ADDR_W-1:0]   cmd_stride,
`endif
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready
);

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [LEN_W-1:0]    r_remain;
  logic [ADDR_W-1:0]   w_step;
  logic                w_issue;
  logic                w_accept;
  logic                w_pipe_valid;
  logic                w_pipe_last;

`ifdef RAM_MASTER_STRIDE_EN
  logic [ADDR_W-1:0] r_stride;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stride <= '0;
    end else if (w_accept) begin
      r_stride <= cmd_stride;
    end
  end

  assign w_step = r_stride;
`else
  assign w_step = ADDR_W'(1);
`endif

  assign w_accept = (r_state == StIdle) && cmd_valid;

  always_comb begin
    w_state_d = r_state;
    w_issue   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_len == '0) begin
            w_state_d = StDone;
          end else if (cmd_write) begin
            w_state_d = StWrite;
          end else begin
            w_state_d = StRead;
          end
        end
      end
      StRead: begin
        w_issue = 1'b1;
        if (r_remain == LEN_W'(1)) begin
          w_state_d = StDrain;
        end
      end
      StDrain: begin
        if (w_pipe_last) begin
          w_state_d = StDone;
        end
      end
      StWrite: begin
        if (wr_valid) begin
          w_issue = 1'b1;
          if (r_remain == LEN_W'(1)) begin
            w_state_d = StDone;
          end
        end
      end
      StDone: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_remain <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_addr   <= cmd_addr;
        r_remain <= cmd_len;
      end else if (w_issue) begin
        // Natural ADDR_W-bit overflow gives the required modulo wrap.
        r_addr   <= r_addr + w_step;
        r_remain <= r_remain - LEN_W'(1);
      end
    end
  end

  ram_rd_latency_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_issue (w_issue && (r_state == StRead)),
    .o_valid (w_pipe_valid),
    .o_last  (w_pipe_last)
  );

  // Strobes are masked while reset is high so an aborted transfer makes no
  // further RAM access and emits none of its in-flight read words.
  assign cmd_ready      = (r_state == StIdle);
  assign busy           = (r_state == StRead) || (r_state == StDrain) || (r_state == StWrite);
  assign done           = (r_state == StDone) && !reset;
  assign avm_address    = r_addr;
  assign avm_chipselect = w_issue && !reset;
  assign avm_write      = w_issue && (r_state == StWrite) && !reset;
  assign avm_writedata  = avm_write ? wr_data : '0;
  assign avm_byteenable = '1;
  assign wr_ready       = (r_state == StWrite) && !reset;
  assign rd_valid       = w_pipe_valid && !reset;
  assign rd_data        = avm_readdata;

endmodule
